// File: rtl/bot_app_pkg.sv
// Shared constants and types for the Rojobot application-side register interface.
package bot_app_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_SNAPX  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_SNAPY  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_INFO   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_SENS   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_MOTCTL = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_BOTCFG = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_OVR    = 3'd7;

    localparam int unsigned ST_IRQ  = 0;
    localparam int unsigned ST_OVR  = 1;
    localparam int unsigned ST_WDOG = 2;

    // Coherent copy of the four BOT system registers taken on an update event.
    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] info;
        logic [DATA_W-1:0] sens;
    } snap_t;

endpackage

// File: rtl/bot_app_if_wdog.sv
// Motor-command watchdog: requests a MotCtl clear after WDOG_CYCLES clocks of
// non-zero MotCtl with no MotCtl write. trip is combinational for the parent's next edge.
module bot_mot_wdog #(
    parameter int unsigned WDOG_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic mot_wr,
    input  logic mot_nonzero,
    output logic trip
);

    localparam int unsigned CNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (WDOG_CYCLES > 0) ? CNT_W'(WDOG_CYCLES - 1) : '0;
    localparam bit WD_EN = (WDOG_CYCLES != 0);

    logic [CNT_W-1:0] wd_cnt_q;
    logic [CNT_W-1:0] wd_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // A write restarts the count and suppresses a trip in the same cycle.
    always_comb begin
        wd_cnt_d = '0;
        trip     = 1'b0;
        if (WD_EN && !mot_wr && mot_nonzero) begin
            if (wd_cnt_q == CNT_LAST) begin
                trip = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bot_app_if.sv
// Application register interface for the Rojobot: update-event IRQ with overrun
// counting, system-register snapshot, MotCtl/BotConfig registers and motor watchdog.
module bot_app_if
    import bot_app_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = 50_000_000,
    parameter int unsigned OVR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] LocX,
    input  logic [DATA_W-1:0] LocY,
    input  logic [DATA_W-1:0] BotInfo,
    input  logic [DATA_W-1:0] Sensors,
    input  logic              upd_sysregs,
    output logic [DATA_W-1:0] MotCtl,
    output logic [DATA_W-1:0] BotConfig,
    input  logic [7:0]        app_addr,
    input  logic              app_wr,
    input  logic              app_rd,
    input  logic [DATA_W-1:0] app_din,
    output logic [DATA_W-1:0] app_dout,
    output logic              irq_req,
    input  logic              irq_ack,
    output logic              wdog_trip
);

    localparam logic [OVR_W-1:0] OVR_MAX = {OVR_W{1'b1}};

    logic              upd_prev_q;
    snap_t             snap_q, snap_d;
    logic              irq_q, irq_d;
    logic [OVR_W-1:0]  ovr_q, ovr_d;
    logic              tripped_q, tripped_d;
    logic [DATA_W-1:0] mot_q, mot_d;
    logic [DATA_W-1:0] cfg_q, cfg_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              trip_q;

    logic              evt_c;
    logic              wr_mot_c, wr_cfg_c, wr_ovr_c;
    logic              trip_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] status_c;
    logic              unused_addr_hi;

    assign addr_c         = app_addr[ADDR_W-1:0];
    assign unused_addr_hi = ^app_addr[7:ADDR_W];

    bot_mot_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk         (clk),
        .reset       (reset),
        .mot_wr      (wr_mot_c),
        .mot_nonzero (mot_q != '0),
        .trip        (trip_c)
    );

    always_ff @(posedge clk) begin
        upd_prev_q <= upd_sysregs;
        if (reset) begin
            snap_q    <= '0;
            irq_q     <= 1'b0;
            ovr_q     <= '0;
            tripped_q <= 1'b0;
            mot_q     <= '0;
            cfg_q     <= '0;
            dout_q    <= '0;
            trip_q    <= 1'b0;
        end else begin
            snap_q    <= snap_d;
            irq_q     <= irq_d;
            ovr_q     <= ovr_d;
            tripped_q <= tripped_d;
            mot_q     <= mot_d;
            cfg_q     <= cfg_d;
            dout_q    <= dout_d;
            trip_q    <= trip_c;
        end
    end

    always_comb begin
        evt_c    = upd_sysregs ^ upd_prev_q;
        wr_mot_c = app_wr && (addr_c == ADDR_MOTCTL);
        wr_cfg_c = app_wr && (addr_c == ADDR_BOTCFG);
        wr_ovr_c = app_wr && (addr_c == ADDR_OVR);

        status_c          = '0;
        status_c[ST_IRQ]  = irq_q;
        status_c[ST_OVR]  = (ovr_q != '0);
        status_c[ST_WDOG] = tripped_q;

        snap_d = snap_q;
        if (evt_c) begin
            snap_d.x    = LocX;
            snap_d.y    = LocY;
            snap_d.info = BotInfo;
            snap_d.sens = Sensors;
        end

        // A new event re-arms the request even when it coincides with an ack.
        irq_d = irq_q;
        if (evt_c) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end

        ovr_d = ovr_q;
        if (wr_ovr_c) begin
            ovr_d = '0;
        end else if (evt_c && irq_q && !irq_ack && (ovr_q != OVR_MAX)) begin
            ovr_d = ovr_q + OVR_W'(1);
        end

        tripped_d = tripped_q;
        if (trip_c) begin
            tripped_d = 1'b1;
        end else if (wr_ovr_c) begin
            tripped_d = 1'b0;
        end

        mot_d = mot_q;
        if (wr_mot_c) begin
            mot_d = app_din;
        end else if (trip_c) begin
            mot_d = '0;
        end

        cfg_d = cfg_q;
        if (wr_cfg_c) begin
            cfg_d = app_din;
        end

        dout_d = dout_q;
        if (app_rd) begin
            case (addr_c)
                ADDR_SNAPX:  dout_d = snap_q.x;
                ADDR_SNAPY:  dout_d = snap_q.y;
                ADDR_INFO:   dout_d = snap_q.info;
                ADDR_SENS:   dout_d = snap_q.sens;
                ADDR_MOTCTL: dout_d = mot_q;
                ADDR_BOTCFG: dout_d = cfg_q;
                ADDR_STATUS: dout_d = status_c;
                default:     dout_d = DATA_W'(ovr_q);
            endcase
        end
    end

    assign MotCtl    = mot_q;
    assign BotConfig = cfg_q;
    assign app_dout  = dout_q;
    assign irq_req   = irq_q;
    assign wdog_trip = trip_q;

endmodule

// File: tb/tb_bot_app_if.sv
// Self-checking bench for bot_app_if: event-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_bot_app_if;

    localparam int unsigned WD      = 16;
    localparam int unsigned OVR_W   = 8;
    localparam int unsigned OVR_SAT = (1 << OVR_W) - 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] LocX = '0, LocY = '0, BotInfo = '0, Sensors = '0;
    logic       upd_sysregs = 1'b0;
    logic [7:0] MotCtl, BotConfig, app_dout;
    logic [7:0] app_addr = '0, app_din = '0;
    logic       app_wr = 1'b0, app_rd = 1'b0, irq_ack = 1'b0;
    logic       irq_req, wdog_trip;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bot_app_if #(
        .WDOG_CYCLES (WD),
        .OVR_W       (OVR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .LocX        (LocX),
        .LocY        (LocY),
        .BotInfo     (BotInfo),
        .Sensors     (Sensors),
        .upd_sysregs (upd_sysregs),
        .MotCtl      (MotCtl),
        .BotConfig   (BotConfig),
        .app_addr    (app_addr),
        .app_wr      (app_wr),
        .app_rd      (app_rd),
        .app_din     (app_din),
        .app_dout    (app_dout),
        .irq_req     (irq_req),
        .irq_ack     (irq_ack),
        .wdog_trip   (wdog_trip)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state after each edge, derived from the register-map rules.
    logic [7:0]  m_snap [4];
    logic        m_irq, m_trip, m_tripped, m_prev;
    int unsigned m_ovr;
    logic [7:0]  m_mot, m_cfg, m_dout;
    longint      edge_no = 0;
    longint      kick_edge = 0;
    bit          model_live = 1'b0;

    function automatic logic [7:0] m_read(input logic [2:0] a);
        case (a)
            3'd0, 3'd1, 3'd2, 3'd3: return m_snap[a];
            3'd4:    return m_mot;
            3'd5:    return m_cfg;
            3'd6:    return {5'b0, m_tripped, (m_ovr != 0), m_irq};
            default: return 8'(m_ovr);
        endcase
    endfunction

    always @(posedge clk) begin
        logic       evt;
        logic [2:0] a;
        edge_no++;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_snap[i] = '0;
            m_irq = 0; m_trip = 0; m_tripped = 0; m_ovr = 0;
            m_mot = '0; m_cfg = '0; m_dout = '0;
            m_prev = upd_sysregs;
            model_live = 1'b1;
        end else begin
            a   = app_addr[2:0];
            evt = (upd_sysregs != m_prev);
            m_prev = upd_sysregs;
            if (app_rd) m_dout = m_read(a);
            if (app_wr && a == 3'd7) m_ovr = 0;
            else if (evt && m_irq && !irq_ack) m_ovr = (m_ovr < OVR_SAT) ? m_ovr + 1 : OVR_SAT;
            if (evt) begin
                m_irq = 1;
                m_snap[0] = LocX; m_snap[1] = LocY; m_snap[2] = BotInfo; m_snap[3] = Sensors;
            end else if (irq_ack) m_irq = 0;
            if (app_wr && a == 3'd7) m_tripped = 0;
            if (app_wr && a == 3'd5) m_cfg = app_din;
            // Watchdog: a non-zero MotCtl expires WD edges after its last write.
            m_trip = 0;
            if (app_wr && a == 3'd4) begin
                m_mot = app_din;
                kick_edge = edge_no;
            end else if (m_mot != 0 && (edge_no - kick_edge) == longint'(WD)) begin
                m_mot = 0; m_trip = 1; m_tripped = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("MotCtl", 32'(MotCtl), 32'(m_mot));
            chk("BotConfig", 32'(BotConfig), 32'(m_cfg));
            chk("app_dout", 32'(app_dout), 32'(m_dout));
            chk("irq_req", 32'(irq_req), 32'(m_irq));
            chk("wdog_trip", 32'(wdog_trip), 32'(m_trip));
        end
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        app_wr = 1; app_addr = a; app_din = d;
        @(negedge clk);
        app_wr = 0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        app_rd = 1; app_addr = a;
        @(negedge clk);
        app_rd = 0;
        chk(name, 32'(app_dout), 32'(exp));
    endtask

    task automatic toggle();
        upd_sysregs = ~upd_sysregs;
        @(negedge clk);
    endtask

    task automatic ack();
        irq_ack = 1;
        @(negedge clk);
        irq_ack = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_irq", 32'(irq_req), 0);
        chk("rst_mot", 32'(MotCtl), 0);
        chk("rst_dout", 32'(app_dout), 0);
        reset = 0;
        @(negedge clk);
        chk("no_evt_after_rst", 32'(irq_req), 0);

        // Single update event, snapshot readback and ack.
        LocX = 8'h12; LocY = 8'h34; BotInfo = 8'h05; Sensors = 8'h1C;
        toggle();
        chk("irq_set", 32'(irq_req), 1);
        rd_chk("rd_x", 8'd0, 8'h12);
        rd_chk("rd_y", 8'd1, 8'h34);
        rd_chk("rd_info", 8'd2, 8'h05);
        rd_chk("rd_sens", 8'd3, 8'h1C);
        ack();
        chk("irq_clr", 32'(irq_req), 0);
        wr(8'd5, 8'h3C);
        rd_chk("rd_cfg", 8'd5, 8'h3C);
        wr(8'd2, 8'hEE);
        rd_chk("ro_ignored", 8'd2, 8'h05);

        // Three events without ack: two overruns, latest snapshot wins.
        for (int k = 0; k < 3; k++) begin
            LocX = 8'h20 + 8'(k); LocY = 8'h30 + 8'(k);
            BotInfo = 8'h40 + 8'(k); Sensors = 8'h50 + 8'(k);
            toggle();
            @(negedge clk);
        end
        chk("irq_hold", 32'(irq_req), 1);
        rd_chk("ovr_2", 8'd7, 8'd2);
        rd_chk("status_3", 8'd6, 8'h03);
        rd_chk("snap3_x", 8'd0, 8'h22);
        rd_chk("snap3_sens", 8'd3, 8'h52);
        wr(8'd7, 8'h00);
        rd_chk("ovr_clr", 8'd7, 8'd0);
        ack();

        // Event coinciding with ack keeps irq set and does not count.
        toggle();
        upd_sysregs = ~upd_sysregs; irq_ack = 1;
        @(negedge clk);
        irq_ack = 0;
        chk("evt_ack_irq", 32'(irq_req), 1);
        rd_chk("evt_ack_ovr", 8'd7, 8'd0);
        ack();

        // Watchdog expiry exactly WD edges after the write.
        wr(8'd4, 8'hA5);
        repeat (WD - 1) @(negedge clk);
        chk("wd_pre_mot", 32'(MotCtl), 32'h A5);
        chk("wd_pre_trip", 32'(wdog_trip), 0);
        @(negedge clk);
        chk("wd_mot0", 32'(MotCtl), 0);
        chk("wd_trip", 32'(wdog_trip), 1);
        @(negedge clk);
        chk("wd_pulse_end", 32'(wdog_trip), 0);
        rd_chk("wd_status", 8'd6, 8'h04);
        wr(8'd7, 8'h00);
        rd_chk("wd_status_clr", 8'd6, 8'h00);

        // Rewrite in the trip cycle wins over the watchdog.
        wr(8'd4, 8'hA5);
        repeat (WD - 1) @(negedge clk);
        wr(8'd4, 8'h5A);
        chk("wd_rewrite_mot", 32'(MotCtl), 32'h5A);
        chk("wd_rewrite_trip", 32'(wdog_trip), 0);
        wr(8'd4, 8'h00);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) upd_sysregs = ~upd_sysregs;
            LocX = 8'($urandom); LocY = 8'($urandom);
            BotInfo = 8'($urandom); Sensors = 8'($urandom);
            irq_ack  = ($urandom_range(5) == 0);
            app_rd   = ($urandom_range(2) == 0);
            app_wr   = ($urandom_range(7) == 0);
            app_addr = 8'($urandom);
            app_din  = 8'($urandom);
            @(negedge clk);
        end
        app_rd = 0; app_wr = 0; irq_ack = 0;

        // Overrun counter saturation.
        wr(8'd4, 8'h00);
        ack();
        wr(8'd7, 8'h00);
        repeat (300) toggle();
        rd_chk("ovr_sat", 8'd7, 8'hFF);
        rd_chk("sat_status", 8'd6, 8'h03);

        // Reset during a pending interrupt with the motor running.
        wr(8'd4, 8'hFF);
        if (!upd_sysregs) toggle();
        chk("pre_rst_irq", 32'(irq_req), 1);
        reset = 1;
        @(negedge clk);
        chk("mid_rst_irq", 32'(irq_req), 0);
        chk("mid_rst_mot", 32'(MotCtl), 0);
        chk("mid_rst_cfg", 32'(BotConfig), 0);
        chk("mid_rst_trip", 32'(wdog_trip), 0);
        reset = 0;
        repeat (5) @(negedge clk);
        chk("post_rst_irq", 32'(irq_req), 0);
        rd_chk("post_rst_ovr", 8'd7, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
